csa_stream_accumulator: RTL and testbench
=========================================

# csa_stream_accumulator

Sequential multi-operand adder for the Booth/Wallace multiplier datapath. It accepts a stream of WIDTH-bit operands, each signed or unsigned and optionally subtracted, and accumulates them in redundant sum/carry form, applying one 3:2 compression per accepted beat. On the transaction's last beat it resolves the redundant pair with one carry-propagate add and presents the result through a valid/ready output. It is the sequential, parametrised generalisation of the combinational carry-save row.

## Interface
- WIDTH, 8: operand width in bits.
- MAX_OPS, 4: maximum number of operands per transaction that is guaranteed overflow-free.
- ACC_WIDTH, WIDTH + $clog2(MAX_OPS) + 1: derived accumulator/result width (local, not overridable).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  WIDTH  operand.
- in_signed  input  1  1: sign-extend in_data; 0: zero-extend.
- in_sub  input  1  1: subtract this operand.
- in_last  input  1  final beat of the transaction.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  ACC_WIDTH  resolved sum, modulo 2^ACC_WIDTH.
- out_ovf  output  1  more than MAX_OPS operands were accepted in this transaction.

## Operation
- States: ACCUM, RESOLVE, OUTPUT. Reset state is ACCUM.
- Registers:
  - acc_s and acc_c are ACC_WIDTH bits; acc_c is stored already weighted (shifted).
  - cnt is $clog2(MAX_OPS+2) bits and saturates at MAX_OPS+1.
  - res holds the resolved result; ovf holds the overflow flag.
- **ACCUM**
  - in_ready=1.
  - On in_valid&&in_ready:
    - x = ext(in_data) to ACC_WIDTH, using in_signed.
    - If in_sub, x = ~x.
    - (s,m) = csa_row(acc_s, acc_c, x).
    - acc_s <= s.
    - acc_c <= {m[ACC_WIDTH-2:0], in_sub}. The injected LSB supplies the +1 of the two's-complement negation.
    - cnt <= sat(cnt+1).
    - If in_last, go to RESOLVE.
- **RESOLVE**
  - in_ready=0.
  - res <= acc_s + acc_c, truncated to ACC_WIDTH.
  - ovf <= (cnt > MAX_OPS).
  - Go to OUTPUT.
- **OUTPUT**
  - in_ready=0; out_valid=1; out_data=res; out_ovf=ovf.
  - On out_ready: acc_s, acc_c and cnt <= 0; go to ACCUM.
- Arithmetic:
  - All sums are modulo 2^ACC_WIDTH.
  - Mixed signed/unsigned beats within one transaction are allowed; each beat is extended per its own in_signed.
  - For ≤ MAX_OPS operands, the result equals the exact mathematical sum, interpreted as signed whenever any beat is signed or subtracted.
- A single-beat transaction (in_last on the first beat) is legal. Zero-operand transactions cannot occur.
- out_ovf is informational only; the result is still emitted modulo 2^ACC_WIDTH.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_ovf=0; acc_s, acc_c, cnt, res, ovf = 0; state=ACCUM.
- Throughput in ACCUM: one operand per cycle.
- Latency:
  - Last beat accepted at edge E.
  - RESOLVE occupies the cycle after E.
  - out_valid=1 from edge E+1.
- in_ready deasserts from edge E until the edge at which the output handshake completes.
- A new beat may be accepted in the cycle immediately after out_valid&&out_ready.
- Back-pressure: while out_ready=0, out_valid, out_data and out_ovf hold stable.
- in_valid while in_ready=0 is ignored. The driver must hold the beat; no beat is lost.
- Reset mid-transaction: the partial sum is discarded, out_valid=0, and the next beat starts a fresh transaction.
- Outputs are registered: out_data and out_ovf come directly from res and ovf; no combinational path from in_* to out_*.

## Structure
- Package csa_pkg holds:
  - the state enum (ACCUM, RESOLVE, OUTPUT);
  - a function acc_width(WIDTH, MAX_OPS) used to derive ACC_WIDTH.
- Sub-module csa_row #(WIDTH): purely combinational bitwise 3:2 compressor row.
  - Inputs a, b, c; outputs s = a^b^c and m = maj(a,b,c).
  - Instantiated once, at ACC_WIDTH.
- The final carry-propagate add is a plain "+" in RESOLVE. No separate CPA module.

## Test plan
All scenarios use WIDTH=8, MAX_OPS=4, ACC_WIDTH=11.
- **Unsigned accumulation.** Unsigned beats 255, 255, 255, 255 (last on the 4th), out_ready=1 → out_data=1020, out_ovf=0. out_valid rises exactly one edge after the last-beat edge and lasts one cycle.
- **Signed accumulation.** Signed beats 0x80, 0x80, 0x7F → out_data = -129 mod 2048 = 1919 (0x77F), out_ovf=0.
- **Subtraction.** Unsigned 10, then unsigned 3 with in_sub=1, last → out_data=7. Also: single beat 5 with in_sub=1 → out_data=2043 (-5).
- **Overflow flag.** Five unsigned beats of value 1 → out_data=5, out_ovf=1. The next transaction of one beat of 9 → out_data=9, out_ovf=0.
- **Back-pressure.** out_ready=0 for 3 cycles after out_valid rises:
  - out_data held stable, in_ready=0;
  - a held in_valid beat is not accepted until the cycle after the handshake.
- **Reset mid-transaction.** Assert rst after two beats of 100, then send a single beat of 42 with last → out_data=42, out_ovf=0. All outputs read their reset values during rst.

Source files
------------

// File: rtl/csa_pkg.sv
// Shared types and helpers for the carry-save stream accumulator.
package csa_pkg;

    typedef enum logic [1:0] {
        ACCUM,
        RESOLVE,
        OUTPUT
    } state_e;

    // Enough headroom for MAX_OPS operands plus a sign bit.
    function automatic int acc_width(input int width, input int max_ops);
        return width + $clog2(max_ops) + 1;
    endfunction

endpackage

// File: rtl/csa_row.sv
// Bitwise 3:2 compressor row: sum and majority (unshifted carry) vectors.
module csa_row #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] m
);

    assign s = a ^ b ^ c;
    assign m = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_stream_accumulator.sv
// Streams operands into a redundant sum/carry pair, resolves with one add
// on the last beat and holds the result behind a valid/ready output.
module csa_stream_accumulator
    import csa_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int MAX_OPS   = 4,
    localparam int ACC_WIDTH = acc_width(WIDTH, MAX_OPS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_signed,
    input  logic                 in_sub,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_ovf
);

    localparam int CNT_W = $clog2(MAX_OPS + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OPS + 1);
    localparam logic [CNT_W-1:0] OPS_LIM = CNT_W'(MAX_OPS);

    state_e               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_s_q, acc_s_d;
    logic [ACC_WIDTH-1:0] acc_c_q, acc_c_d;
    logic [ACC_WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;

    logic [ACC_WIDTH-1:0] ext_x;
    logic [ACC_WIDTH-1:0] op_x;
    logic [ACC_WIDTH-1:0] row_s;
    logic [ACC_WIDTH-1:0] row_m;
    logic                 unused_m;

    assign ext_x = {{(ACC_WIDTH-WIDTH){in_signed & in_data[WIDTH-1]}}, in_data};
    assign op_x  = in_sub ? ~ext_x : ext_x;

    csa_row #(
        .WIDTH(ACC_WIDTH)
    ) u_row (
        .a(acc_s_q),
        .b(acc_c_q),
        .c(op_x),
        .s(row_s),
        .m(row_m)
    );

    // The top majority bit weighs 2^ACC_WIDTH and vanishes modulo the width.
    assign unused_m = row_m[ACC_WIDTH-1];

    assign out_data = res_q;
    assign out_ovf  = ovf_q;

    always_comb begin
        state_d   = state_q;
        acc_s_d   = acc_s_q;
        acc_c_d   = acc_c_q;
        res_d     = res_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_s_d = row_s;
                    // LSB injection completes ~x + 1 for subtracted beats.
                    acc_c_d = {row_m[ACC_WIDTH-2:0], in_sub};
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (in_last) begin
                        state_d = RESOLVE;
                    end
                end
            end
            RESOLVE: begin
                res_d   = acc_s_q + acc_c_q;
                ovf_d   = (cnt_q > OPS_LIM);
                state_d = OUTPUT;
            end
            OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_s_d = '0;
                    acc_c_d = '0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_s_q <= '0;
            acc_c_q <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_s_q <= acc_s_d;
            acc_c_q <= acc_c_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Directed and randomized transactions checked against an integer-sum model.
module tb_csa_stream_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_signed;
    logic        in_sub;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_data;
    logic        out_ovf;

    int n_chk  = 0;
    int n_pass = 0;

    csa_stream_accumulator #(
        .WIDTH(8),
        .MAX_OPS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_signed(in_signed),
        .in_sub(in_sub),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic beat(input logic [7:0] d, input logic s, input logic sub,
                        input logic last);
        int k;
        in_valid  = 1'b1;
        in_data   = d;
        in_signed = s;
        in_sub    = sub;
        in_last   = last;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) chk("beat_wait_in_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_sub   = 1'b0;
    endtask

    task automatic finish_txn(input logic [10:0] exp_d, input logic exp_o,
                              input string tag);
        chk({tag, "_resolve_out_valid"}, out_valid, 0);
        chk({tag, "_resolve_in_ready"}, in_ready, 0);
        @(negedge clk);
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_out_data"}, out_data, exp_d);
        chk({tag, "_out_ovf"}, out_ovf, exp_o);
        @(negedge clk);
        chk({tag, "_done_out_valid"}, out_valid, 0);
        chk({tag, "_done_in_ready"}, in_ready, 1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_signed = 1'b0;
        in_sub    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ovf", out_ovf, 0);
        rst = 1'b0;
        @(negedge clk);

        repeat (3) beat(8'd255, 1'b0, 1'b0, 1'b0);
        beat(8'd255, 1'b0, 1'b0, 1'b1);
        finish_txn(11'd1020, 1'b0, "unsigned");

        repeat (2) beat(8'h80, 1'b1, 1'b0, 1'b0);
        beat(8'h7f, 1'b1, 1'b0, 1'b1);
        finish_txn(11'd1919, 1'b0, "signed");

        beat(8'd10, 1'b0, 1'b0, 1'b0);
        beat(8'd3, 1'b0, 1'b1, 1'b1);
        finish_txn(11'd7, 1'b0, "sub");
        beat(8'd5, 1'b0, 1'b1, 1'b1);
        finish_txn(11'd2043, 1'b0, "neg_single");

        repeat (4) beat(8'd1, 1'b0, 1'b0, 1'b0);
        beat(8'd1, 1'b0, 1'b0, 1'b1);
        finish_txn(11'd5, 1'b1, "ovf");
        beat(8'd9, 1'b0, 1'b0, 1'b1);
        finish_txn(11'd9, 1'b0, "after_ovf");

        out_ready = 1'b0;
        beat(8'd7, 1'b0, 1'b0, 1'b1);
        chk("bp_resolve_out_valid", out_valid, 0);
        @(negedge clk);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_out_data", out_data, 7);
        in_valid  = 1'b1;
        in_data   = 8'd20;
        in_signed = 1'b0;
        in_sub    = 1'b0;
        in_last   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_data", out_data, 7);
            chk("bp_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_out_valid", out_valid, 0);
        chk("bp_hs_in_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        chk("bp_accept_in_ready", in_ready, 0);
        chk("bp_accept_out_valid", out_valid, 0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        chk("bp_held_beat_valid", out_valid, 1);
        chk("bp_held_beat_data", out_data, 20);
        @(negedge clk);

        repeat (2) beat(8'd100, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_out_ovf", out_ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        beat(8'd42, 1'b0, 1'b0, 1'b1);
        finish_txn(11'd42, 1'b0, "post_rst");

        for (int t = 0; t < 24; t++) begin
            int          nops;
            int          sum;
            logic [7:0]  d;
            logic        s;
            logic        sub;
            logic signed [7:0] sd;
            nops = (t % 6 == 5) ? int'($urandom_range(5, 7))
                                : int'($urandom_range(1, 4));
            sum = 0;
            for (int k = 0; k < nops; k++) begin
                d   = 8'($urandom);
                s   = 1'($urandom);
                sub = 1'($urandom);
                sd  = d;
                if (sub) sum -= (s ? int'(sd) : int'({24'b0, d}));
                else     sum += (s ? int'(sd) : int'({24'b0, d}));
                beat(d, s, sub, k == nops - 1);
            end
            finish_txn(11'(sum), nops > 4, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
